onehot_decoder_seq: RTL and testbench

//  Parametrised, registered address-to-one-hot decoder with an index register.

---
 rtl/onehot_decoder_seq.sv | 113 +++++++++++
 tb/tb_onehot_decoder_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/onehot_decoder_seq.sv
// Registered address-to-one-hot decoder with an index register and four modes:
// hold, single-cycle pulse, scan-up and scan-down.
module onehot_decoder_seq #(
    parameter int ADDR_W  = 3,
    parameter int NUM_OUT = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               load,
    input  logic               step,
    input  logic [1:0]         mode,
    input  logic [ADDR_W-1:0]  address,
    output logic [NUM_OUT-1:0] out,
    output logic [ADDR_W-1:0]  index,
    output logic               active,
    output logic               wrap,
    output logic               err
);

    typedef enum logic [1:0] {
        MODE_HOLD      = 2'b00,
        MODE_PULSE     = 2'b01,
        MODE_SCAN_UP   = 2'b10,
        MODE_SCAN_DOWN = 2'b11
    } mode_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_OUT - 1);

    mode_t               mode_s;
    logic                addr_ok;
    logic                was_pulse;
    logic [ADDR_W-1:0]   index_n;
    logic                active_n;
    logic                wrap_n;
    logic                err_n;
    logic [NUM_OUT-1:0]  out_n;

    assign mode_s  = mode_t'(mode);
    assign addr_ok = (int'(address) < NUM_OUT);

    always_comb begin
        index_n  = index;
        active_n = active;
        wrap_n   = 1'b0;
        err_n    = 1'b0;
        if (!enable) begin
            active_n = 1'b0;
        end else if (load) begin
            if (addr_ok) begin
                index_n  = address;
                active_n = 1'b1;
            end else begin
                err_n = 1'b1;
            end
        end else begin
            case (mode_s)
                // A pulse left over from PULSE mode must not be latched by HOLD.
                MODE_HOLD:  if (was_pulse) active_n = 1'b0;
                MODE_PULSE: active_n = 1'b0;
                MODE_SCAN_UP: begin
                    active_n = 1'b1;
                    if (step) begin
                        if (index == LAST_IDX) begin
                            index_n = '0;
                            wrap_n  = 1'b1;
                        end else begin
                            index_n = index + ADDR_W'(1);
                        end
                    end
                end
                MODE_SCAN_DOWN: begin
                    active_n = 1'b1;
                    if (step) begin
                        if (index == '0) begin
                            index_n = LAST_IDX;
                            wrap_n  = 1'b1;
                        end else begin
                            index_n = index - ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        out_n = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            out_n[i] = active_n && (index_n == ADDR_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index     <= '0;
            active    <= 1'b0;
            wrap      <= 1'b0;
            err       <= 1'b0;
            out       <= '0;
            was_pulse <= 1'b0;
        end else begin
            index     <= index_n;
            active    <= active_n;
            wrap      <= wrap_n;
            err       <= err_n;
            out       <= out_n;
            was_pulse <= (mode_s == MODE_PULSE);
        end
    end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Bench for onehot_decoder_seq (ADDR_W=3, NUM_OUT=6): directed scenarios with
// literal expectations plus randomized traffic checked against a reference model.
module tb_onehot_decoder_seq;

    localparam int ADDR_W  = 3;
    localparam int NUM_OUT = 6;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               enable = 1'b0;
    logic               load = 1'b0;
    logic               step = 1'b0;
    logic [1:0]         mode = 2'b00;
    logic [ADDR_W-1:0]  address = '0;
    logic [NUM_OUT-1:0] out;
    logic [ADDR_W-1:0]  index;
    logic               active;
    logic               wrap;
    logic               err;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_on   = 1'b0;

    // reference model state
    int m_index;
    bit m_active, m_wrap, m_err, m_prev_pulse;

    onehot_decoder_seq #(.ADDR_W(ADDR_W), .NUM_OUT(NUM_OUT)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .step(step),
        .mode(mode), .address(address), .out(out), .index(index),
        .active(active), .wrap(wrap), .err(err)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                      name, act, act, exp, exp, $time);
    endfunction

    // Model: what the outputs must be after each edge, from the mode rules.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_index = 0; m_active = 0; m_wrap = 0; m_err = 0; m_prev_pulse = 0;
        end else begin
            m_wrap = 0;
            m_err  = 0;
            if (!enable) m_active = 0;
            else if (load) begin
                if (int'(address) < NUM_OUT) begin
                    m_index = int'(address);
                    m_active = 1;
                end else m_err = 1;
            end else if (mode == 2'b10) begin
                m_active = 1;
                if (step) begin
                    m_wrap  = (m_index == NUM_OUT - 1);
                    m_index = (m_index + 1) % NUM_OUT;
                end
            end else if (mode == 2'b11) begin
                m_active = 1;
                if (step) begin
                    m_wrap  = (m_index == 0);
                    m_index = (m_index + NUM_OUT - 1) % NUM_OUT;
                end
            end else if (mode == 2'b01 || m_prev_pulse) m_active = 0;
            m_prev_pulse = (mode == 2'b01);
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("cmp_out",    int'(out),    m_active ? (1 << m_index) : 0);
            check("cmp_index",  int'(index),  m_index);
            check("cmp_active", int'(active), int'(m_active));
            check("cmp_wrap",   int'(wrap),   int'(m_wrap));
            check("cmp_err",    int'(err),    int'(m_err));
        end
    end

    task automatic tick(int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(bit en, bit ld, bit st, logic [1:0] md, int addr);
        enable  = en;
        load    = ld;
        step    = st;
        mode    = md;
        address = ADDR_W'(addr);
    endtask

    initial begin
        // reset state
        tick(2);
        check("reset_out",   int'(out), 0);
        check("reset_index", int'(index), 0);
        check("reset_flags", int'({active, wrap, err}), 0);
        rst_n  = 1'b1;
        cmp_on = 1'b1;

        // HOLD: load 5, then held
        drive(1, 1, 0, 2'b00, 5); tick();
        check("hold_out", int'(out), 6'b10_0000);
        check("hold_active", int'(active), 1);
        drive(1, 0, 1, 2'b00, 0); tick(10);
        check("hold_out_10", int'(out), 6'b10_0000);

        // PULSE: back-to-back loads
        drive(1, 1, 0, 2'b01, 2); tick();
        check("pulse_out_a", int'(out), 8'h04);
        drive(1, 1, 0, 2'b01, 3); tick();
        check("pulse_out_b", int'(out), 8'h08);
        drive(1, 0, 0, 2'b01, 0); tick();
        check("pulse_out_end", int'(out), 0);
        check("pulse_active_end", int'(active), 0);

        // SCAN_UP 4 -> 5 -> 0 -> 1
        drive(1, 1, 0, 2'b10, 4); tick();
        check("scan_idx4", int'(index), 4);
        drive(1, 0, 1, 2'b10, 0); tick();
        check("scan_idx5", int'(index), 5);
        check("scan_nowrap5", int'(wrap), 0);
        tick();
        check("scan_idx0", int'(index), 0);
        check("scan_wrap0", int'(wrap), 1);
        check("model_wrap0", int'(m_wrap), 1);
        tick();
        check("scan_idx1", int'(index), 1);
        check("scan_nowrap1", int'(wrap), 0);

        // SCAN_DOWN from 0 -> 5 with wrap
        drive(1, 1, 0, 2'b11, 0); tick();
        drive(1, 0, 1, 2'b11, 0); tick();
        check("down_idx5", int'(index), 5);
        check("down_wrap", int'(wrap), 1);
        check("model_down_idx", m_index, 5);

        // out-of-range load while index=2 active
        drive(1, 1, 0, 2'b00, 2); tick();
        drive(1, 1, 0, 2'b00, 7); tick();
        check("oor_err", int'(err), 1);
        check("oor_index", int'(index), 2);
        check("oor_out", int'(out), 8'h04);
        check("model_err", int'(m_err), 1);
        drive(1, 0, 0, 2'b00, 0); tick();
        check("oor_err_clear", int'(err), 0);

        // load beats step; then enable drop
        drive(1, 1, 0, 2'b10, 3); tick();
        drive(1, 1, 1, 2'b10, 1); tick();
        check("ldstep_idx", int'(index), 1);
        check("ldstep_wrap", int'(wrap), 0);
        drive(0, 0, 0, 2'b10, 0); tick();
        check("dis_out", int'(out), 0);
        check("dis_idx", int'(index), 1);

        // async reset mid-scan
        drive(1, 1, 0, 2'b10, 4); tick();
        drive(1, 0, 1, 2'b10, 0); tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_out", int'(out), 0);
        check("arst_index", int'(index), 0);
        check("arst_flags", int'({active, wrap, err}), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("arst_step_idx", int'(index), 1);

        // randomized traffic, with occasional mid-cycle resets
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 7));
            if (i % 97 == 50) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            tick();
        end

        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
